queue_ctrl_8x4: RTL and testbench

QUEUE_CTRL_8X4 -- requirements
Module: queue_ctrl_8x4

---
 rtl/queue_ctrl_8x4_pkg.sv | 21 ++
 rtl/queue_ctrl_8x4_ram.sv | 25 ++
 rtl/queue_ctrl_8x4.sv | 76 +++++++
 tb/tb_queue_ctrl_8x4.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/queue_ctrl_8x4_pkg.sv
// Shared constants and types for the 8-deep, 4-bit queue controller.
package queue_ctrl_8x4_pkg;

    localparam int DEPTH = 8;
    localparam int WIDTH = 4;
    localparam int AW    = 3;
    localparam int CW    = 4;

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [AW-1:0]    ptr_t;
    typedef logic [CW-1:0]    cnt_t;

    localparam cnt_t COUNT_FULL  = cnt_t'(DEPTH);
    localparam cnt_t COUNT_EMPTY = '0;

    // Pointer advance; AW bits wrap 7->0 naturally.
    function automatic ptr_t ptr_next(input ptr_t p);
        return p + ptr_t'(1);
    endfunction

endpackage

// File: rtl/queue_ctrl_8x4_ram.sv
// 8x4 synchronous 1R1W RAM: registered read, write on rising edge.
module xst_ram_1r1w_synch_8_4_0 (
    input  logic       clk,
    input  logic       we,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic [2:0] rd_addr,
    output logic [3:0] rd_data
);

    logic [3:0] mem [0:7];

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; data appears the cycle after the address.
    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/queue_ctrl_8x4.sv
// Queue controller around an external 8x4 RAM: pointers, occupancy, flags.
module queue_ctrl_8x4
    import queue_ctrl_8x4_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_ready,
    input  logic             pop,
    output logic             pop_ready,
    output logic             pop_valid,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    ptr_t  wr_ptr;
    ptr_t  rd_ptr;
    word_t ram_rd_data;
    logic  push_acc;
    logic  pop_acc;

    assign full       = (count == COUNT_FULL);
    assign empty      = (count == COUNT_EMPTY);
    assign push_ready = !full;
    assign pop_ready  = !empty;

    // A full queue refuses pushes even alongside a pop, so the RAM never
    // sees a write and a read to the same slot in one cycle.
    assign push_acc = push && !full;
    assign pop_acc  = pop && !empty;

    // The RAM read is registered, so its output lines up with pop_valid.
    assign pop_data = pop_valid ? ram_rd_data : '0;

    xst_ram_1r1w_synch_8_4_0 u_ram (
        .clk     (clk),
        .we      (push_acc),
        .wr_addr (wr_ptr),
        .wr_data (push_data),
        .rd_addr (rd_ptr),
        .rd_data (ram_rd_data)
    );

    // Pointers, occupancy and the registered status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop_acc) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push_acc, pop_acc})
                2'b10:   count <= count + cnt_t'(1);
                2'b01:   count <= count - cnt_t'(1);
                default: count <= count;
            endcase
            pop_valid <= pop_acc;
            overflow  <= push && full;
            underflow <= pop && empty;
        end
    end

endmodule

// File: tb/tb_queue_ctrl_8x4.sv
// Self-checking bench for queue_ctrl_8x4: vector table plus data scoreboard.
module tb_queue_ctrl_8x4;

    logic       clk = 1'b0;
    logic       reset;
    logic       push;
    logic [3:0] push_data;
    logic       push_ready;
    logic       pop;
    logic       pop_ready;
    logic       pop_valid;
    logic [3:0] pop_data;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       underflow;

    queue_ctrl_8x4 dut (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_data  (push_data),
        .push_ready (push_ready),
        .pop        (pop),
        .pop_ready  (pop_ready),
        .pop_valid  (pop_valid),
        .pop_data   (pop_data),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       push;
        bit [3:0] d;
        bit       pop;
        int       cnt;
        bit       ovf;
        bit       unf;
    } vec_t;

    vec_t     tab[$];
    bit [3:0] model_q[$];
    bit [3:0] sb[$];
    int       model_cnt;
    bit       exp_valid;
    int       n_vec;
    int       n_err;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input bit p, input bit [3:0] d, input bit q,
                                input int c, input bit o, input bit u);
        vec_t v;
        v.push = p; v.d = d; v.pop = q; v.cnt = c; v.ovf = o; v.unf = u;
        tab.push_back(v);
    endfunction

    // One clock: drive at negedge, update model, check #1 after posedge.
    task automatic step(input bit p, input bit [3:0] d, input bit q,
                        input int c, input bit o, input bit u);
        bit       pa;
        bit       qa;
        bit [3:0] w;
        @(negedge clk);
        push = p; push_data = d; pop = q;
        chk("push_ready", int'(push_ready), int'(model_cnt < 8));
        chk("pop_ready", int'(pop_ready), int'(model_cnt > 0));
        pa = p && (model_cnt < 8);
        qa = q && (model_cnt > 0);
        if (qa) begin
            w = model_q.pop_front();
            sb.push_back(w);
        end
        if (pa) model_q.push_back(d);
        model_cnt = model_cnt + int'(pa) - int'(qa);
        exp_valid = qa;
        @(posedge clk);
        #1;
        chk("count", int'(count), c);
        chk("full", int'(full), int'(c == 8));
        chk("empty", int'(empty), int'(c == 0));
        chk("overflow", int'(overflow), int'(o));
        chk("underflow", int'(underflow), int'(u));
        chk("pop_valid", int'(pop_valid), int'(exp_valid));
        if (exp_valid) begin
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 1, 0);
            end else begin
                w = sb.pop_front();
                chk("pop_data", int'(pop_data), int'(w));
            end
        end else begin
            chk("pop_data_idle", int'(pop_data), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_err = 0; model_cnt = 0; exp_valid = 0;
        push = 0; pop = 0; push_data = '0;
        reset = 1'b1;
        #12;
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_pop_valid", int'(pop_valid), 0);
        chk("rst_pop_data", int'(pop_data), 0);
        @(negedge clk);
        reset = 1'b0;
        step(0, 4'h0, 0, 0, 0, 0);

        // Fill 1..8, drain in order.
        for (int i = 0; i < 8; i++) add(1, 4'(i + 1), 0, i + 1, 0, 0);
        for (int i = 0; i < 8; i++) add(0, 4'h0, 1, 7 - i, 0, 0);
        // Refill, then push 4'hF alongside a pop while full.
        for (int i = 0; i < 8; i++) add(1, 4'(i + 3), 0, i + 1, 0, 0);
        add(1, 4'hF, 1, 7, 1, 0);
        add(0, 4'h0, 0, 7, 0, 0);
        for (int i = 0; i < 7; i++) add(0, 4'h0, 1, 6 - i, 0, 0);
        // Pop alongside push 4'hA while empty.
        add(1, 4'hA, 1, 1, 0, 1);
        add(0, 4'h0, 1, 0, 0, 0);
        add(0, 4'h0, 0, 0, 0, 0);
        add(0, 4'h0, 1, 0, 0, 1);
        add(0, 4'h0, 0, 0, 0, 0);

        foreach (tab[k]) step(tab[k].push, tab[k].d, tab[k].pop,
                              tab[k].cnt, tab[k].ovf, tab[k].unf);

        // Pointer wrap: hold count at 3 through 12 push/pop pairs.
        for (int i = 0; i < 3; i++) step(1, 4'(i + 1), 0, i + 1, 0, 0);
        for (int i = 0; i < 12; i++) step(1, 4'(i + 4), 1, 3, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 4'h0, 1, 2 - i, 0, 0);
        step(0, 4'h0, 0, 0, 0, 0);

        // Asynchronous reset between edges at count 5.
        for (int i = 0; i < 5; i++) step(1, 4'(i + 9), 0, i + 1, 0, 0);
        @(negedge clk);
        push = 0; pop = 0;
        #2 reset = 1'b1;
        #1;
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_empty", int'(empty), 1);
        chk("async_rst_full", int'(full), 0);
        chk("async_rst_pop_data", int'(pop_data), 0);
        model_q.delete(); sb.delete(); model_cnt = 0; exp_valid = 0;
        @(negedge clk);
        reset = 1'b0;
        step(1, 4'h6, 0, 1, 0, 0);
        step(0, 4'h0, 1, 0, 0, 0);
        step(0, 4'h0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
